pad_key_decoder: RTL

PAD_KEY_DECODER -- requirements
Module: pad_key_decoder

---
 rtl/pad_key_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pad_key_decoder.sv
// PS/2 set-2 byte decoder for a two-player pad game: tracks held W/S/Up/Down keys and pulses on Space press.
// Optional idle watchdog that force-releases held keys is enabled by defining KEY_WATCHDOG_EN.
module pad_key_decoder #(
   parameter int WDOG_CYCLES = 65_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic       p1_up,
   output logic       p1_down,
   output logic       p2_up,
   output logic       p2_down,
   output logic       start_pulse
);

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BREAK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE,
      BRK,
      EXT,
      EXT_BRK
   } state_t;

   state_t state_reg, state_next;

   logic p1_up_reg, p1_up_next;
   logic p1_down_reg, p1_down_next;
   logic p2_up_reg, p2_up_next;
   logic p2_down_reg, p2_down_next;
   logic space_held_reg, space_held_next;
   logic start_reg, start_next;

   logic key_event;
   logic key_break;
   logic key_ext;
   logic any_held;

   assign any_held = p1_up_reg | p1_down_reg | p2_up_reg | p2_down_reg | space_held_reg;

`ifdef KEY_WATCHDOG_EN
   localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] wd_reg;
   logic            wd_expire;

   // A byte arriving in the expiry cycle takes priority over the force-release.
   assign wd_expire = !scan_valid && (wd_reg == WD_MAX);

   always_ff @(posedge clk) begin
      if (rst || scan_valid || wd_expire) begin
         wd_reg <= '0;
      end else if (any_held) begin
         wd_reg <= wd_reg + 1'b1;
      end
   end
`endif

   always_comb begin
      state_next      = state_reg;
      p1_up_next      = p1_up_reg;
      p1_down_next    = p1_down_reg;
      p2_up_next      = p2_up_reg;
      p2_down_next    = p2_down_reg;
      space_held_next = space_held_reg;
      start_next      = 1'b0;
      key_event       = 1'b0;
      key_break       = 1'b0;
      key_ext         = 1'b0;

      if (scan_valid) begin
         case (state_reg)
            IDLE: begin
               if (scan_code == CODE_BREAK)    state_next = BRK;
               else if (scan_code == CODE_EXT) state_next = EXT;
               else                            key_event  = 1'b1;
            end
            EXT: begin
               if (scan_code == CODE_BREAK)    state_next = EXT_BRK;
               else if (scan_code == CODE_EXT) state_next = EXT;
               else begin
                  key_event  = 1'b1;
                  key_ext    = 1'b1;
                  state_next = IDLE;
               end
            end
            BRK: begin
               if (scan_code == CODE_BREAK)    state_next = BRK;
               else if (scan_code == CODE_EXT) state_next = EXT;
               else begin
                  key_event  = 1'b1;
                  key_break  = 1'b1;
                  state_next = IDLE;
               end
            end
            EXT_BRK: begin
               if (scan_code == CODE_BREAK)    state_next = EXT_BRK;
               else if (scan_code == CODE_EXT) state_next = EXT;
               else begin
                  key_event  = 1'b1;
                  key_break  = 1'b1;
                  key_ext    = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end

      // Extended flag is part of the key identity, so 0x75 and E0 75 never alias.
      if (key_event) begin
         case ({key_ext, scan_code})
            9'h01D: p1_up_next   = !key_break;
            9'h01B: p1_down_next = !key_break;
            9'h175: p2_up_next   = !key_break;
            9'h172: p2_down_next = !key_break;
            9'h029: begin
               if (!key_break && !space_held_reg) start_next = 1'b1;
               space_held_next = !key_break;
            end
            default: ;
         endcase
      end

`ifdef KEY_WATCHDOG_EN
      if (wd_expire) begin
         state_next      = IDLE;
         p1_up_next      = 1'b0;
         p1_down_next    = 1'b0;
         p2_up_next      = 1'b0;
         p2_down_next    = 1'b0;
         space_held_next = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         p1_up_reg      <= 1'b0;
         p1_down_reg    <= 1'b0;
         p2_up_reg      <= 1'b0;
         p2_down_reg    <= 1'b0;
         space_held_reg <= 1'b0;
         start_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         p1_up_reg      <= p1_up_next;
         p1_down_reg    <= p1_down_next;
         p2_up_reg      <= p2_up_next;
         p2_down_reg    <= p2_down_next;
         space_held_reg <= space_held_next;
         start_reg      <= start_next;
      end
   end

   assign p1_up       = p1_up_reg;
   assign p1_down     = p1_down_reg;
   assign p2_up       = p2_up_reg;
   assign p2_down     = p2_down_reg;
   assign start_pulse = start_reg;

endmodule
